// File: rtl/argon_bus_pkg.sv
// rtl/argon_bus_pkg.sv - shared types for the argon Wishbone arbiter
package argon_bus_pkg;

  typedef enum logic {
    ARB_FIXED       = 1'b0,
    ARB_ROUND_ROBIN = 1'b1
  } arb_mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  localparam int MAX_MASTERS = 8;

endpackage

// File: rtl/arb_rr_picker.sv
// rtl/arb_rr_picker.sv - rotate-priority one-hot request picker
// Fixed mode always scans from index 0; round-robin scans from last+1.
module arb_rr_picker
  import argon_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int LAST_WIDTH  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [LAST_WIDTH-1:0]  i_last,
  input  logic                   i_mode,
  output logic [NUM_MASTERS-1:0] o_grant
);

  int   w_start;
  int   w_idx;
  logic w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    w_start = (i_mode == ARB_ROUND_ROBIN) ? ((int'(i_last) + 1) % NUM_MASTERS) : 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_idx = (w_start + i) % NUM_MASTERS;
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wishbone_arbiter.sv
// rtl/wishbone_arbiter.sv - N-master to 1-slave classic Wishbone arbiter
// Grant is held for a whole cyc burst; a watchdog error-terminates unacked strobes.
module wishbone_arbiter
  import argon_bus_pkg::*;
#(
  parameter int        NUM_MASTERS = 2,
  parameter int        ADDR_WIDTH  = 32,
  parameter int        DATA_WIDTH  = 32,
  parameter arb_mode_t ARB_MODE    = ARB_ROUND_ROBIN,
  parameter int        TIMEOUT     = 256
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_MASTERS-1:0]               i_m_cyc,
  input  logic [NUM_MASTERS-1:0]               i_m_stb,
  input  logic [NUM_MASTERS-1:0]               i_m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    i_m_adr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    i_m_dat,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  i_m_sel,
  output logic [NUM_MASTERS-1:0]               o_m_ack,
  output logic [NUM_MASTERS-1:0]               o_m_err,
  output logic [DATA_WIDTH-1:0]                o_m_dat,
  output logic [NUM_MASTERS-1:0]               o_grant,
  output logic                                 o_s_cyc,
  output logic                                 o_s_stb,
  output logic                                 o_s_we,
  output logic [ADDR_WIDTH-1:0]                o_s_adr,
  output logic [DATA_WIDTH-1:0]                o_s_dat,
  output logic [DATA_WIDTH/8-1:0]              o_s_sel,
  input  logic                                 i_s_ack,
  input  logic [DATA_WIDTH-1:0]                i_s_dat
);

  localparam int N  = NUM_MASTERS;
  localparam int SW = DATA_WIDTH / 8;
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WD_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [LW-1:0] LAST_RST = LW'(N - 1);

  arb_state_t    r_state, w_state_nxt;
  logic [N-1:0]  r_grant, w_grant_nxt, w_pick;
  logic [LW-1:0] r_last, w_last_nxt, w_pick_idx, w_owner;
  logic [CW-1:0] r_wd_cnt;
  logic          w_owned, w_own_cyc, w_own_stb, w_expire;

  arb_rr_picker #(
    .NUM_MASTERS (N),
    .LAST_WIDTH  (LW)
  ) u_picker (
    .i_req   (i_m_cyc),
    .i_last  (r_last),
    .i_mode  (ARB_MODE),
    .o_grant (w_pick)
  );

  always_comb begin
    w_pick_idx = '0;
    w_owner    = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick[i])  w_pick_idx = LW'(i);
      if (r_grant[i]) w_owner    = LW'(i);
    end
  end

  assign w_owned   = (r_state == ST_OWNED);
  assign w_own_cyc = i_m_cyc[w_owner];
  assign w_own_stb = i_m_stb[w_owner];
  // A same-cycle ack beats expiry, so the transfer completes normally.
  assign w_expire  = (TIMEOUT != 0) && w_owned && w_own_stb && !i_s_ack &&
                     (r_wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= LAST_RST;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (|i_m_cyc) begin
          w_state_nxt = ST_OWNED;
          w_grant_nxt = w_pick;
          w_last_nxt  = w_pick_idx;
        end
      end
      ST_OWNED: begin
        if (!w_own_cyc || w_expire) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd_cnt <= '0;
    end else if (!w_owned || i_s_ack) begin
      r_wd_cnt <= '0;
    end else if (w_own_stb && (TIMEOUT != 0)) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign o_grant = r_grant;
  assign o_s_cyc = w_owned & w_own_cyc & ~w_expire;
  assign o_s_stb = w_owned & w_own_stb & ~w_expire;
  assign o_s_we  = w_owned & i_m_we[w_owner];
  assign o_s_adr = w_owned ? i_m_adr[w_owner*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign o_s_dat = w_owned ? i_m_dat[w_owner*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign o_s_sel = w_owned ? i_m_sel[w_owner*SW +: SW] : '0;
  assign o_m_ack = {N{w_owned & i_s_ack}} & r_grant;
  assign o_m_err = {N{w_expire}} & r_grant;
  assign o_m_dat = i_s_dat;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// tb/tb_wishbone_arbiter.sv - self-checking bench for wishbone_arbiter
`timescale 1ns/1ps
module tb_wishbone_arbiter;
  import argon_bus_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // round-robin instance, N=4, TIMEOUT=8
  logic            rst;
  logic [N-1:0]    cyc, stb, we;
  logic [AW-1:0]   adr_a [N];
  logic [DW-1:0]   dat_a [N];
  logic [DW/8-1:0] sel_a [N];
  logic [N*AW-1:0] adr_bus;
  logic [N*DW-1:0] dat_bus;
  logic [N*DW/8-1:0] sel_bus;
  logic            ack;
  logic [DW-1:0]   sdat;
  logic [N-1:0]    m_ack, m_err, grant;
  logic [DW-1:0]   m_dat, s_dat;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_adr;
  logic [DW/8-1:0] s_sel;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      adr_bus[k*AW +: AW]     = adr_a[k];
      dat_bus[k*DW +: DW]     = dat_a[k];
      sel_bus[k*DW/8 +: DW/8] = sel_a[k];
    end
  end

  wishbone_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ARB_MODE(ARB_ROUND_ROBIN), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(rst),
    .i_m_cyc(cyc), .i_m_stb(stb), .i_m_we(we),
    .i_m_adr(adr_bus), .i_m_dat(dat_bus), .i_m_sel(sel_bus),
    .o_m_ack(m_ack), .o_m_err(m_err), .o_m_dat(m_dat), .o_grant(grant),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we),
    .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_sel(s_sel),
    .i_s_ack(ack), .i_s_dat(sdat)
  );

  // fixed-priority instance, N=2, watchdog disabled
  logic        f_rst;
  logic [1:0]  f_cyc, f_m_ack, f_m_err, f_grant;
  logic        f_ack, f_s_cyc, f_s_stb, f_s_we;
  logic [31:0] f_m_dat, f_s_adr, f_s_dat;
  logic [3:0]  f_s_sel;

  wishbone_arbiter #(
    .NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .ARB_MODE(ARB_FIXED), .TIMEOUT(0)
  ) dut_fx (
    .clk(clk), .reset(f_rst),
    .i_m_cyc(f_cyc), .i_m_stb(f_cyc), .i_m_we(2'b01),
    .i_m_adr({32'h0000_0200, 32'h0000_0100}),
    .i_m_dat({32'h2222_2222, 32'h1111_1111}), .i_m_sel(8'hFF),
    .o_m_ack(f_m_ack), .o_m_err(f_m_err), .o_m_dat(f_m_dat), .o_grant(f_grant),
    .o_s_cyc(f_s_cyc), .o_s_stb(f_s_stb), .o_s_we(f_s_we),
    .o_s_adr(f_s_adr), .o_s_dat(f_s_dat), .o_s_sel(f_s_sel),
    .i_s_ack(f_ack), .i_s_dat(32'h5A5A_0000)
  );

  typedef struct packed {
    logic         rst;
    logic [N-1:0] cyc;
    logic         ack;
    logic [N-1:0] e_grant;
    logic         e_scyc;
    logic [N-1:0] e_ack;
    logic [N-1:0] e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [N-1:0] c, input logic a,
                     input logic [N-1:0] eg, input logic esc,
                     input logic [N-1:0] ea, input logic [N-1:0] ee);
    vec_t v;
    v.rst = r; v.cyc = c; v.ack = a;
    v.e_grant = eg; v.e_scyc = esc; v.e_ack = ea; v.e_err = ee;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] adr_of(input logic [N-1:0] g);
    adr_of = '0;
    for (int k = 0; k < N; k++) if (g[k]) adr_of = 32'h100 + 32'h10 * k;
  endfunction

  task automatic fx(input logic [1:0] c, input logic a, input logic [1:0] eg,
                    input logic esc, input logic [1:0] ea, input logic [1:0] ee,
                    input string nm);
    logic [31:0] ea_adr;
    f_cyc = c; f_ack = a;
    @(negedge clk);
    ea_adr = (eg == 2'b01) ? 32'h100 : (eg == 2'b10) ? 32'h200 : 32'h0;
    chk({nm, " grant"}, f_grant, eg);
    chk({nm, " s_cyc"}, f_s_cyc, esc);
    chk({nm, " m_ack"}, f_m_ack, ea);
    chk({nm, " m_err"}, f_m_err, ee);
    chk({nm, " s_adr"}, f_s_adr, ea_adr);
    @(posedge clk); #1;
  endtask

  // reference model state: owner -1 means no owner
  int mo_owner, mo_last, mo_cnt;

  initial begin
    logic [N-1:0] oh;
    logic [6:0]   beats;
    vec_t         v;
    logic [N-1:0] e_grant, e_ack, e_err;
    logic         e_scyc, e_sstb, e_we, expire_e;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [DW/8-1:0] e_sel;

    rst = 1'b1; f_rst = 1'b1; cyc = '0; stb = '0; we = '0; ack = 1'b0; sdat = '0;
    f_cyc = '0; f_ack = 1'b0;
    for (int k = 0; k < N; k++) begin
      adr_a[k] = 32'h100 + 32'h10 * k;
      dat_a[k] = 32'h1000 + k;
      sel_a[k] = 4'hF;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; f_rst = 1'b0;

    // single master 1-beat read, slave acks after 2 cycles
    add(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b0001, 0, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b0001, 0, 4'b0001, 1, 4'b0000, 4'b0000);
    add(0, 4'b0001, 0, 4'b0001, 1, 4'b0000, 4'b0000);
    add(0, 4'b0001, 1, 4'b0001, 1, 4'b0001, 4'b0000);
    add(0, 4'b0000, 0, 4'b0001, 0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000);
    add(1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000);
    // round robin, all requesting, 1-beat bursts: order 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << (i % 4);
      add(0, 4'b1111, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 4'b1111, 1, oh, 1, oh, 4'b0000);
      add(0, 4'b1111 & ~oh, 0, oh, 0, 4'b0000, 4'b0000);
    end
    // burst hold: m1 does 4 beats while m0 waits
    add(0, 4'b0011, 0, 4'b0000, 0, 4'b0000, 4'b0000);
    beats = 7'b1011010;
    for (int i = 0; i < 7; i++)
      add(0, 4'b0011, beats[i], 4'b0010, 1, beats[i] ? 4'b0010 : 4'b0000, 4'b0000);
    add(0, 4'b0001, 0, 4'b0010, 0, 4'b0000, 4'b0000);
    add(0, 4'b0001, 0, 4'b0000, 0, 4'b0000, 4'b0000);
    // watchdog expiry on the 8th owned cycle
    for (int i = 0; i < 7; i++) add(0, 4'b0001, 0, 4'b0001, 1, 4'b0000, 4'b0000);
    add(0, 4'b0001, 0, 4'b0001, 0, 4'b0000, 4'b0001);
    add(0, 4'b0001, 0, 4'b0000, 0, 4'b0000, 4'b0000);
    // ack in the expiry cycle wins
    for (int i = 0; i < 7; i++) add(0, 4'b0001, 0, 4'b0001, 1, 4'b0000, 4'b0000);
    add(0, 4'b0001, 1, 4'b0001, 1, 4'b0001, 4'b0000);
    add(0, 4'b0000, 0, 4'b0001, 0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000);
    // reset mid-burst, then round robin restarts at m0
    add(0, 4'b0100, 0, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b0100, 0, 4'b0100, 1, 4'b0000, 4'b0000);
    add(1, 4'b0100, 0, 4'b0100, 1, 4'b0000, 4'b0000);
    add(0, 4'b1111, 0, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b1111, 1, 4'b0001, 1, 4'b0001, 4'b0000);
    add(0, 4'b1110, 0, 4'b0001, 0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst = v.rst; cyc = v.cyc; stb = v.cyc; ack = v.ack; sdat = 32'hCAFE_0000 + i;
      @(negedge clk);
      chk($sformatf("tbl%0d grant", i), grant, v.e_grant);
      chk($sformatf("tbl%0d s_cyc", i), s_cyc, v.e_scyc);
      chk($sformatf("tbl%0d m_ack", i), m_ack, v.e_ack);
      chk($sformatf("tbl%0d m_err", i), m_err, v.e_err);
      chk($sformatf("tbl%0d s_adr", i), s_adr, adr_of(v.e_grant));
      chk($sformatf("tbl%0d m_dat", i), m_dat, 32'hCAFE_0000 + i);
      @(posedge clk); #1;
    end

    // fixed priority contention, watchdog disabled
    fx(2'b11, 0, 2'b00, 0, 2'b00, 2'b00, "fx req");
    for (int i = 0; i < 12; i++) fx(2'b11, 0, 2'b01, 1, 2'b00, 2'b00, "fx m0 hold");
    fx(2'b11, 1, 2'b01, 1, 2'b01, 2'b00, "fx m0 ack");
    fx(2'b10, 0, 2'b01, 0, 2'b00, 2'b00, "fx m0 drop");
    fx(2'b10, 0, 2'b00, 0, 2'b00, 2'b00, "fx dead");
    fx(2'b10, 0, 2'b10, 1, 2'b00, 2'b00, "fx m1 grant");
    fx(2'b11, 1, 2'b10, 1, 2'b10, 2'b00, "fx m1 ack");
    fx(2'b01, 0, 2'b10, 0, 2'b00, 2'b00, "fx m1 drop");
    fx(2'b01, 0, 2'b00, 0, 2'b00, 2'b00, "fx dead2");
    fx(2'b01, 0, 2'b01, 1, 2'b00, 2'b00, "fx m0 again");
    fx(2'b10, 0, 2'b01, 0, 2'b00, 2'b00, "fx m0 drop2");
    fx(2'b11, 0, 2'b00, 0, 2'b00, 2'b00, "fx both idle");
    fx(2'b11, 0, 2'b01, 1, 2'b00, 2'b00, "fx lowest wins");
    fx(2'b00, 0, 2'b01, 0, 2'b00, 2'b00, "fx release");
    fx(2'b00, 0, 2'b00, 0, 2'b00, 2'b00, "fx idle");

    // randomized traffic against the reference model
    rst = 1'b1; cyc = '0; stb = '0; ack = 1'b0;
    @(posedge clk); #1;
    mo_owner = -1; mo_last = N - 1; mo_cnt = 0;
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 7) == 0) cyc[k] = ~cyc[k];
        stb[k]   = cyc[k] & ($urandom_range(0, 3) != 0);
        we[k]    = 1'($urandom);
        adr_a[k] = $urandom;
        dat_a[k] = $urandom;
        sel_a[k] = 4'($urandom);
      end
      ack  = (c < 1000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      sdat = $urandom;
      @(negedge clk);
      e_grant = '0; e_ack = '0; e_err = '0; e_scyc = 0; e_sstb = 0; e_we = 0;
      e_adr = '0; e_dat = '0; e_sel = '0; expire_e = 0;
      if (mo_owner >= 0) begin
        expire_e = (mo_cnt == TO - 1) && stb[mo_owner] && !ack;
        e_grant[mo_owner] = 1'b1;
        e_scyc = cyc[mo_owner] && !expire_e;
        e_sstb = stb[mo_owner] && !expire_e;
        e_we   = we[mo_owner];
        e_adr  = adr_a[mo_owner];
        e_dat  = dat_a[mo_owner];
        e_sel  = sel_a[mo_owner];
        if (ack) e_ack = e_grant;
        if (expire_e) e_err = e_grant;
      end
      chk($sformatf("rnd%0d grant", c), grant, e_grant);
      chk($sformatf("rnd%0d s_cyc", c), s_cyc, e_scyc);
      chk($sformatf("rnd%0d s_stb", c), s_stb, e_sstb);
      chk($sformatf("rnd%0d s_we", c), s_we, e_we);
      chk($sformatf("rnd%0d s_adr", c), s_adr, e_adr);
      chk($sformatf("rnd%0d s_dat", c), s_dat, e_dat);
      chk($sformatf("rnd%0d s_sel", c), s_sel, e_sel);
      chk($sformatf("rnd%0d m_ack", c), m_ack, e_ack);
      chk($sformatf("rnd%0d m_err", c), m_err, e_err);
      chk($sformatf("rnd%0d m_dat", c), m_dat, sdat);
      if (rst) begin
        mo_owner = -1; mo_last = N - 1; mo_cnt = 0;
      end else if (mo_owner < 0) begin
        for (int i = 1; i <= N; i++)
          if (mo_owner < 0 && cyc[(mo_last + i) % N]) mo_owner = (mo_last + i) % N;
        if (mo_owner >= 0) begin
          mo_last = mo_owner;
          mo_cnt  = 0;
        end
      end else if (!cyc[mo_owner] || expire_e) begin
        mo_owner = -1;
        mo_cnt   = 0;
      end else if (ack) begin
        mo_cnt = 0;
      end else if (stb[mo_owner]) begin
        mo_cnt++;
      end
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wishbone_arbiter.md
# wishbone_arbiter

Parametrised N-master to 1-slave Wishbone (classic, non-pipelined) arbiter for the argon CPU subsystem. Lets the instruction-fetch master, the load/store master and future masters (debug, DMA) share one memory bus. Supports fixed-priority or round-robin selection, holds the grant for a whole `cyc` burst, and has a watchdog that error-terminates transfers the slave never acknowledges.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of master channels, 2..8.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width; a multiple of 8.
- `ARB_MODE`, `ARB_ROUND_ROBIN`: `arb_mode_t`, either `ARB_FIXED` or `ARB_ROUND_ROBIN`.
- `TIMEOUT`, 256: cycles without `ack` before error termination; 0 disables the watchdog.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `i_m_cyc` in N: per-master `cyc`.
- `i_m_stb` in N: per-master `stb`.
- `i_m_we` in N: per-master `we`.
- `i_m_adr` in N*ADDR_WIDTH: packed addresses; master k occupies slice [k*AW +: AW].
- `i_m_dat` in N*DATA_WIDTH: packed write data.
- `i_m_sel` in N*DATA_WIDTH/8: packed byte selects.
- `o_m_ack` out N: per-master `ack`.
- `o_m_err` out N: per-master `err`, driven only by the watchdog.
- `o_m_dat` out DATA_WIDTH: slave read data, broadcast to all masters.
- `o_grant` out N: one-hot current owner; all zero in IDLE.
- `o_s_cyc`, `o_s_stb`, `o_s_we` out 1: slave-side control.
- `o_s_adr` out ADDR_WIDTH, `o_s_dat` out DATA_WIDTH, `o_s_sel` out DATA_WIDTH/8: slave-side address, write data and byte selects.
- `i_s_ack` in 1, `i_s_dat` in DATA_WIDTH: slave acknowledge and read data.

## Operation
- FSM with two states.
  - IDLE: no owner. If any `i_m_cyc` is high, the picker result is registered into `o_grant` and the state moves to OWNED.
  - OWNED: the owner's `cyc/stb/we/adr/dat/sel` drive the slave-side outputs combinationally. `i_s_ack` is routed only to the owner's `o_m_ack`.
  - OWNED → IDLE when the owner drops `cyc` (sampled at the edge), or on watchdog expiry.
- Fixed mode: the lowest-index requester wins.
- Round-robin mode: the search starts at `last+1` modulo N. `last` updates on every grant.
- The grant is held for all beats while the owner keeps `cyc` high. No preemption.
- In IDLE, all slave-side outputs are 0 and all `o_m_ack`/`o_m_err` are 0.
- Watchdog:
  - Counter clears on grant and on every `i_s_ack`.
  - It increments each OWNED cycle in which `o_s_stb` is high and `i_s_ack` is low.
  - When the counter reaches TIMEOUT-1 while still un-acked, `o_m_err[owner]` pulses for 1 cycle, slave `cyc/stb` are forced low that cycle, and the next state is IDLE.
- An `ack` and expiry in the same cycle: `ack` wins and no error is raised.
- `o_m_dat` = `i_s_dat` at all times.

## Timing
- Reset values:
  - state IDLE, `o_grant` = 0, `last` = N-1 (so master 0 gets the first round-robin grant), watchdog counter = 0.
  - All outputs are 0.
- Arbitration latency: `cyc` rising in IDLE at cycle t gives `o_grant` and slave `cyc` high in cycle t+1.
- `ack` passes to the master combinationally, with zero added latency.
- Release: owner `cyc` low at edge t gives IDLE in cycle t+1 and the earliest new grant in t+2. There is one dead cycle between owners.
- Reset asserted mid-transfer: IDLE on the next edge and slave `cyc` drops. No `ack` or `err` is produced for the aborted transfer.
- Requests that arrive while OWNED wait; none are lost (level-sensitive `cyc`).

## Structure
- `argon_bus_pkg` holds `arb_mode_t` and a localparam for the maximum master count.
- Sub-module `arb_rr_picker`: combinational rotate-priority encoder.
  - Inputs: request vector, `last` pointer, mode.
  - Output: one-hot winner.
- The arbiter top holds the FSM, the watchdog counter and the muxes.

## Test plan
- Single master, N=2: m0 performs a 1-beat read of 0x100 with the slave acking after 2 cycles → `o_grant`=01 in the cycle after `cyc`; `o_m_ack[0]` in the `ack` cycle; `o_m_dat` = slave data.
- Contention in fixed mode: m0 and m1 raise `cyc` in the same cycle → m0 is granted first. m1 is granted 2 cycles after m0 drops `cyc`.
- Round robin, N=4: all masters request continuously with 1-beat bursts → grant order 0,1,2,3,0.
- Burst hold: m1 performs 4 beats under one `cyc` while m0 requests → m0 is not granted until m1 releases. Exactly 4 acks go to m1 and none to m0.
- Watchdog, TIMEOUT=8: the slave never acks → `o_m_err[owner]` pulses once, 8 cycles after grant; the state returns to IDLE. Repeat with the `ack` arriving in the expiry cycle → `ack` only, no `err`.
- Reset mid-burst: `reset` asserted while OWNED → next cycle `o_grant`=0 and `o_s_cyc`=0. After reset, round robin restarts at master 0.
